// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU execute stage.
//   OP_*          one-hot select codes, bit i of {R3,R2,R1,R0} = decoder output Ri
//   flags_t       registered flag bundle, bit order {err, ovf, zero, carry}
//   sel_illegal   1 when a select is anything other than exactly one-hot
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b1000;

    typedef struct packed {
        logic err;
        logic ovf;
        logic zero;
        logic carry;
    } flags_t;

    // Covers both the all-zero select and any multi-hot select.
    function automatic logic sel_illegal(input logic [3:0] sel);
        case (sel)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b0;
            default:                       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU placed between pipeline stage 1 and stage 2.
//   sel     in  4   one-hot select {R3,R2,R1,R0}
//   a, b    in  W   operands (unsigned; two's complement for ovf)
//   result  out W   operation result, 0 on an illegal select
//   carry   out 1   ADD carry-out, SUB borrow (a<b), 0 otherwise
//   zero    out 1   result == 0 for a legal select
//   ovf     out 1   signed overflow for ADD/SUB, 0 otherwise
//   err     out 1   select was not exactly one-hot
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [3:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         ovf,
    output logic         err
);

    // One extra bit holds carry-out for ADD; for SUB the top bit is the borrow.
    logic [W:0] sum;
    logic [W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (sel)
            OP_ADD: begin
                result = sum[W-1:0];
                carry  = sum[W];
                ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                result = diff[W-1:0];
                carry  = diff[W];
                ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: err = 1'b1;
        endcase
        // An illegal select reports only err; zero stays low.
        zero = (result == '0) && !err;
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage valid/ready execute pipeline for the 4-bit ALU.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake for R0..R3, a, b
//   R0..R3                    one-hot select ADD/SUB/AND/OR
//   a, b                      operands
//   out_valid / out_ready     downstream handshake
//   result, carry, zero, ovf  registered result and flags
//   err                       registered illegal-select indication
//   err_cnt                   saturating count of illegal selects accepted
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int W      = 4,
    parameter int ECNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              R0,
    input  logic              R1,
    input  logic              R2,
    input  logic              R3,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      result,
    output logic              carry,
    output logic              zero,
    output logic              ovf,
    output logic              err,
    output logic [ECNT_W-1:0] err_cnt
);

    logic              vld_p1_q;
    logic [3:0]        sel_p1_q;
    logic [W-1:0]      a_p1_q;
    logic [W-1:0]      b_p1_q;
    logic              vld_p2_q;
    logic [W-1:0]      result_p2_q;
    flags_t            flags_p2_q;
    logic [ECNT_W-1:0] err_cnt_q;
    logic [ECNT_W-1:0] err_cnt_d;

    logic [3:0]   sel_in;
    logic         s1_load;
    logic         s2_load;
    logic [W-1:0] core_result;
    flags_t       core_flags;

    assign sel_in = {R3, R2, R1, R0};

    // A stage loads when it is empty or its contents move on this cycle, so
    // a bubble is filled even while the output stalls.
    assign s2_load  = !vld_p2_q || out_ready;
    assign s1_load  = !vld_p1_q || s2_load;
    assign in_ready = s1_load;

    // ---- Stage 1: capture operands and select ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (s1_load) begin
            vld_p1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            sel_p1_q <= sel_in;
            a_p1_q   <= a;
            b_p1_q   <= b;
        end
    end

    alu_core #(.W(W)) u_core (
        .sel    (sel_p1_q),
        .a      (a_p1_q),
        .b      (b_p1_q),
        .result (core_result),
        .carry  (core_flags.carry),
        .zero   (core_flags.zero),
        .ovf    (core_flags.ovf),
        .err    (core_flags.err)
    );

    // ---- Stage 2: register ALU output, held while stalled ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q    <= 1'b0;
            result_p2_q <= '0;
            flags_p2_q  <= '0;
        end else if (s2_load) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                result_p2_q <= core_result;
                flags_p2_q  <= core_flags;
            end
        end
    end

    // Counted at acceptance into stage 1, saturating at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_valid && s1_load && sel_illegal(sel_in) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign result    = result_p2_q;
    assign carry     = flags_p2_q.carry;
    assign zero      = flags_p2_q.zero;
    assign ovf       = flags_p2_q.ovf;
    assign err       = flags_p2_q.err;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
module tb_alu_exec_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic       R0, R1, R2, R3;
    logic [3:0] a, b;
    logic       out_valid, out_ready;
    logic [3:0] result;
    logic       carry, zero, ovf, err;
    logic [7:0] err_cnt;

    // Second instance with a 2-bit counter for saturation.
    logic       t2_rst, t2_in_valid, t2_in_ready, t2_out_valid;
    logic [3:0] t2_result;
    logic       t2_carry, t2_zero, t2_ovf, t2_err;
    logic [1:0] t2_err_cnt;

    always #5 clk = ~clk;

    alu_exec_pipe #(.W(4), .ECNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .zero(zero), .ovf(ovf), .err(err), .err_cnt(err_cnt)
    );

    alu_exec_pipe #(.W(4), .ECNT_W(2)) dut2 (
        .clk(clk), .rst(t2_rst), .in_valid(t2_in_valid), .in_ready(t2_in_ready),
        .R0(1'b0), .R1(1'b0), .R2(1'b0), .R3(1'b0), .a(4'h0), .b(4'h0),
        .out_valid(t2_out_valid), .out_ready(1'b1), .result(t2_result),
        .carry(t2_carry), .zero(t2_zero), .ovf(t2_ovf), .err(t2_err), .err_cnt(t2_err_cnt)
    );

    // exp packs {err, ovf, zero, carry, result}
    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } op_t;

    op_t        stim_q[$];
    logic [7:0] sb_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         err_model = 0;
    bit         saw_low;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [7:0] ref_op(input logic [3:0] sel, input logic [3:0] xa, input logic [3:0] xb);
        int ua, ub, sa, sb, r, s;
        bit c, v, z;
        ua = int'(xa); ub = int'(xb);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        c = 0; v = 0;
        case (sel)
            4'b0001: begin r = ua + ub; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
            4'b0010: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 7) || (s < -8); end
            4'b0100: r = ua & ub;
            4'b1000: r = ua | ub;
            default: return 8'h80;
        endcase
        r = r & 15;
        z = (r == 0);
        return {1'b0, v, z, c, r[3:0]};
    endfunction

    function automatic op_t mk(input logic [3:0] sel, input logic [3:0] xa, input logic [3:0] xb, input logic [7:0] exp);
        op_t o;
        o.sel = sel; o.a = xa; o.b = xb; o.exp = exp;
        return o;
    endfunction

    function automatic logic [7:0] obs_now();
        return {err, ovf, zero, carry, result};
    endfunction

    // Drives the stimulus queue through the DUT and checks every output transfer.
    task automatic run(input int max_cyc, input bit rnd, input int bp_lo, input int bp_hi);
        int         c;
        bit         prev_stall;
        logic [7:0] prev_obs;
        op_t        op;
        c = 0;
        prev_stall = 0;
        prev_obs = '0;
        while ((stim_q.size() > 0 || sb_q.size() > 0) && c < max_cyc) begin
            @(negedge clk);
            chk_eq("err_cnt", err_cnt, err_model);
            if (prev_stall) chk_eq("hold", {out_valid, obs_now()}, {1'b1, prev_obs});
            if (stim_q.size() > 0) begin
                {R3, R2, R1, R0} = stim_q[0].sel;
                a = stim_q[0].a;
                b = stim_q[0].b;
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                {R3, R2, R1, R0} = 4'($urandom);
                a = 4'($urandom);
                b = 4'($urandom);
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(c >= bp_lo && c <= bp_hi);
            #1;
            if (!rnd && c >= bp_lo && c <= bp_hi && !in_ready) saw_low = 1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk_eq("unexpected_out", out_valid, 1'b0);
                else chk_eq("out", obs_now(), sb_q.pop_front());
            end
            if (in_valid && in_ready) begin
                op = stim_q.pop_front();
                sb_q.push_back(op.exp);
                if (op.exp[7] && err_model < 255) err_model++;
            end
            prev_stall = out_valid && !out_ready;
            prev_obs = obs_now();
            c++;
        end
        chk_eq("drain", stim_q.size() + sb_q.size(), 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int   cnt2;
        logic [3:0] s;
        rst = 1'b1; in_valid = 1'b1; {R3, R2, R1, R0} = 4'b0001;
        a = 4'h1; b = 4'h1; out_ready = 1'b1;
        t2_rst = 1'b1; t2_in_valid = 1'b0;

        // Reset held for two cycles with in_valid asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_out_valid", out_valid, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk_eq("rst_in_ready", in_ready, 1'b1);
        chk_eq("rst_err_cnt", err_cnt, 0);
        chk_eq("rst_outputs", {out_valid, obs_now()}, 9'h0);

        // Directed operations with literal expectations.
        stim_q.push_back(mk(4'b0001, 4'h9, 4'h8, 8'h51));
        stim_q.push_back(mk(4'b0010, 4'h3, 4'h5, 8'h1E));
        stim_q.push_back(mk(4'b0010, 4'h5, 4'h5, 8'h20));
        stim_q.push_back(mk(4'b0100, 4'hC, 4'hA, 8'h08));
        stim_q.push_back(mk(4'b1000, 4'hC, 4'hA, 8'h0E));
        stim_q.push_back(mk(4'b0000, 4'h7, 4'h3, 8'h80));
        stim_q.push_back(mk(4'b0011, 4'h7, 4'h3, 8'h80));
        run(100, 1'b0, 1000, 1000);
        chk_eq("err_cnt_directed", err_cnt, 2);

        // Backpressure: six ADDs, output stalled for cycles 3..6.
        saw_low = 0;
        for (int i = 0; i < 6; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            stim_q.push_back(mk(4'b0001, a, b, ref_op(4'b0001, a, b)));
        end
        run(100, 1'b0, 3, 6);
        chk_eq("bp_in_ready_low", saw_low, 1'b1);

        // Randomised stream with random valid/ready.
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            a = 4'($urandom); b = 4'($urandom);
            stim_q.push_back(mk(s, a, b, ref_op(s, a, b)));
        end
        run(3000, 1'b1, 0, 0);

        // Reset with a full pipe of illegal ops discards everything.
        @(negedge clk);
        in_valid = 1'b1; {R3, R2, R1, R0} = 4'b0000; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("mid_full", {out_valid, in_ready}, 2'b10);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk_eq("mid_rst_out_valid", out_valid, 1'b0);
        chk_eq("mid_rst_err_cnt", err_cnt, 0);
        chk_eq("mid_rst_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk_eq("mid_rst_no_ghost", out_valid, 1'b0);
        err_model = 0;

        // Saturation with a 2-bit counter.
        @(negedge clk);
        t2_rst = 1'b0;
        cnt2 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            t2_in_valid = 1'b1;
            #1;
            if (t2_in_ready) cnt2++;
        end
        @(negedge clk);
        t2_in_valid = 1'b0;
        chk_eq("t2_accepts", cnt2, 5);
        chk_eq("t2_err_cnt_sat", t2_err_cnt, (cnt2 > 3) ? 3 : cnt2);
        @(negedge clk);
        chk_eq("t2_err_flag", {t2_err, t2_result}, 5'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
